// File: rtl/sprite_line_cull.sv
// Per-scanline sprite culler: walks every stmeta entry once per start and builds
// an index-ordered list of sprites covering line_y, with X clamped to the screen.
module sprite_line_cull #(
  parameter int SPRITE_COUNT = 128,
  parameter int MAX_PER_LINE = 16,
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 240,
  localparam int IDX_W = $clog2(SPRITE_COUNT),
  localparam int LST_W = $clog2(MAX_PER_LINE),
  localparam int ENT_W = IDX_W + 8 + 16 + 9 + 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       line_y,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] stmeta_raddr,
  input  logic [119:0]     stmeta_read_data,
  output logic [LST_W:0]   list_count,
  output logic             overflow,
  input  logic [LST_W-1:0] list_raddr,
  output logic [ENT_W-1:0] list_rdata
);

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(SPRITE_COUNT - 1);
  localparam logic [LST_W:0]     CNT_MAX  = (LST_W + 1)'(MAX_PER_LINE);
  localparam logic signed [15:0] X_MAX    = 16'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PRIME, SCAN, FINISH} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] scan_idx;
  logic [7:0]       line_q;
  logic [ENT_W-1:0] list_mem [MAX_PER_LINE];

  logic [7:0]        f_tex;
  logic signed [15:0] f_ty, f_h, f_sy, f_ey, f_sx, f_ex, row_s;
  logic [15:0]       unused_screen_x;
  logic              row_ok, visible, room;
  logic [8:0]        xstart, xend;

  assign f_tex           = stmeta_read_data[119:112];
  assign f_ty            = stmeta_read_data[111:96];
  assign unused_screen_x = stmeta_read_data[95:80];
  assign f_h             = stmeta_read_data[79:64];
  assign f_sy            = stmeta_read_data[63:48];
  assign f_ey            = stmeta_read_data[47:32];
  assign f_sx            = stmeta_read_data[31:16];
  assign f_ex            = stmeta_read_data[15:0];
  assign row_s           = {8'd0, line_q};

  // An out-of-range row simply yields an empty list rather than garbage.
  assign row_ok  = {8'd0, line_q} < 16'(HEIGHT);
  assign visible = row_ok && (f_ty > 16'sd0) && (f_h != 16'sd0) &&
                   (f_sy <= row_s) && (row_s <= f_ey) &&
                   (f_ex >= 16'sd0) && (f_sx <= X_MAX);
  assign room    = (list_count != CNT_MAX);

  // Visibility guarantees both bounds already fit in 9 bits after clamping.
  assign xstart = (f_sx < 16'sd0) ? 9'd0 : f_sx[8:0];
  assign xend   = (f_ex > X_MAX) ? X_MAX[8:0] : f_ex[8:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nx = PRIME;
      PRIME:  begin busy = 1'b1; state_nx = SCAN; end
      SCAN:   begin busy = 1'b1; if (scan_idx == IDX_LAST) state_nx = FINISH; end
      FINISH: begin done = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
  end

  // stmeta_raddr runs one ahead of scan_idx to cover the RAM read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stmeta_raddr <= '0;
      scan_idx     <= '0;
      line_q       <= '0;
      list_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stmeta_raddr <= '0;
          scan_idx     <= '0;
          if (start) begin
            line_q     <= line_y;
            list_count <= '0;
            overflow   <= 1'b0;
          end
        end
        PRIME: stmeta_raddr <= IDX_W'(1);
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (stmeta_raddr != IDX_LAST) stmeta_raddr <= stmeta_raddr + 1'b1;
          if (visible) begin
            if (room) list_count <= list_count + 1'b1;
            else      overflow   <= 1'b1;
          end
        end
        FINISH: stmeta_raddr <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == SCAN && visible && room)
      list_mem[list_count[LST_W-1:0]] <= {scan_idx, f_tex, f_ty, xstart, xend};
  end

  assign list_rdata = list_mem[list_raddr];

endmodule

// File: tb/tb_sprite_line_cull.sv
// Directed bench for sprite_line_cull with a synchronous-read stmeta RAM model.
module tb_sprite_line_cull;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   line_y = 8'd0;
  logic         busy, done, overflow;
  logic [6:0]   stmeta_raddr;
  logic [119:0] stmeta_read_data = '0;
  logic [4:0]   list_count;
  logic [3:0]   list_raddr = 4'd0;
  logic [48:0]  list_rdata;

  logic [119:0] ram [128];
  int total = 0;
  int bad   = 0;
  int lat;
  bit seq_ok;

  sprite_line_cull dut (
    .clk(clk), .rst(rst), .start(start), .line_y(line_y),
    .busy(busy), .done(done), .stmeta_raddr(stmeta_raddr),
    .stmeta_read_data(stmeta_read_data), .list_count(list_count),
    .overflow(overflow), .list_raddr(list_raddr), .list_rdata(list_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) stmeta_read_data <= ram[stmeta_raddr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [119:0] mk(input logic [7:0] tex, input logic [15:0] ty,
                                      input logic [15:0] h, input logic [15:0] sy,
                                      input logic [15:0] ey, input logic [15:0] sx0,
                                      input logic [15:0] ex0);
    return {tex, ty, 16'd160, h, sy, ey, sx0, ex0};
  endfunction

  function automatic logic [48:0] ent(input logic [6:0] idx, input logic [7:0] tex,
                                      input logic [15:0] dep, input logic [8:0] xs,
                                      input logic [8:0] xe);
    return {idx, tex, dep, xs, xe};
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = '0;
  endtask

  task automatic rd_list(input int i, output logic [48:0] v);
    list_raddr = 4'(i);
    #1;
    v = list_rdata;
  endtask

  // Runs one scan; restart_at re-pulses start (with a different row) at that cycle.
  task automatic do_scan(input logic [7:0] ly, input int restart_at,
                         output int l, output bit ok);
    @(negedge clk);
    start  = 1'b1;
    line_y = ly;
    l  = 0;
    ok = 1'b1;
    while (l < 400) begin
      @(negedge clk);
      l++;
      start = (l == restart_at);
      if (start) line_y = 8'd99;
      if (l <= 128 && stmeta_raddr != 7'(l - 1)) ok = 1'b0;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    logic [48:0] v;
    clear_ram();
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(list_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_raddr", 64'(stmeta_raddr), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // single sprite
    ram[5] = mk(8'h2A, 16'h0200, 16'd40, 16'd100, 16'd140, 16'd140, 16'd180);
    do_scan(8'd120, -1, lat, seq_ok);
    chk("single_lat", 64'(lat), 64'd130);
    chk("single_busy_at_done", 64'(busy), 64'd0);
    chk("single_seq", 64'(seq_ok), 64'd1);
    chk("single_count", 64'(list_count), 64'd1);
    chk("single_ovf", 64'(overflow), 64'd0);
    rd_list(0, v);
    chk("single_e0", 64'(v), 64'(ent(7'd5, 8'h2A, 16'h0200, 9'd140, 9'd180)));

    // row boundaries
    do_scan(8'd100, -1, lat, seq_ok);
    chk("row100", 64'(list_count), 64'd1);
    do_scan(8'd140, -1, lat, seq_ok);
    chk("row140", 64'(list_count), 64'd1);
    do_scan(8'd99, -1, lat, seq_ok);
    chk("row99", 64'(list_count), 64'd0);
    do_scan(8'd141, -1, lat, seq_ok);
    chk("row141", 64'(list_count), 64'd0);

    // clamping and off-screen rejection
    clear_ram();
    ram[3]  = mk(8'h11, 16'h0180, 16'd10, 16'd0, 16'd200, 16'hFFE2, 16'd350);
    ram[7]  = mk(8'h12, 16'h0180, 16'd10, 16'd0, 16'd200, 16'hFFD0, 16'hFFFF);
    ram[8]  = mk(8'h13, 16'h0180, 16'd10, 16'd0, 16'd200, 16'd320, 16'd400);
    ram[9]  = mk(8'h14, 16'hFF00, 16'd10, 16'd0, 16'd200, 16'd10, 16'd20);
    ram[10] = mk(8'h15, 16'h0180, 16'd0, 16'd0, 16'd200, 16'd10, 16'd20);
    ram[12] = mk(8'h16, 16'h0300, 16'd10, 16'd0, 16'd200, 16'd319, 16'd0);
    do_scan(8'd120, -1, lat, seq_ok);
    chk("clip_count", 64'(list_count), 64'd2);
    rd_list(0, v);
    chk("clip_e0", 64'(v), 64'(ent(7'd3, 8'h11, 16'h0180, 9'd0, 9'd319)));
    rd_list(1, v);
    chk("clip_e1", 64'(v), 64'(ent(7'd12, 8'h16, 16'h0300, 9'd319, 9'd0)));

    // overflow, then recovery
    clear_ram();
    for (int i = 0; i < 20; i++)
      ram[i] = mk(8'(i), 16'h0100, 16'd5, 16'd50, 16'd60, 16'(i), 16'(i + 8));
    do_scan(8'd55, -1, lat, seq_ok);
    chk("ovf_count", 64'(list_count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    rd_list(15, v);
    chk("ovf_e15", 64'(v), 64'(ent(7'd15, 8'd15, 16'h0100, 9'd15, 9'd23)));
    clear_ram();
    ram[30] = mk(8'h30, 16'h0100, 16'd5, 16'd50, 16'd60, 16'd1, 16'd2);
    ram[40] = mk(8'h40, 16'h0100, 16'd5, 16'd50, 16'd60, 16'd3, 16'd4);
    ram[50] = mk(8'h50, 16'h0100, 16'd5, 16'd50, 16'd60, 16'd5, 16'd6);
    do_scan(8'd55, -1, lat, seq_ok);
    chk("rec_count", 64'(list_count), 64'd3);
    chk("rec_ovf", 64'(overflow), 64'd0);
    rd_list(2, v);
    chk("rec_e2", 64'(v), 64'(ent(7'd50, 8'h50, 16'h0100, 9'd5, 9'd6)));

    // start re-pulsed mid-scan is ignored
    clear_ram();
    ram[5] = mk(8'h2A, 16'h0200, 16'd40, 16'd100, 16'd140, 16'd140, 16'd180);
    do_scan(8'd120, 50, lat, seq_ok);
    chk("restart_lat", 64'(lat), 64'd130);
    chk("restart_count", 64'(list_count), 64'd1);
    rd_list(0, v);
    chk("restart_e0", 64'(v), 64'(ent(7'd5, 8'h2A, 16'h0200, 9'd140, 9'd180)));

    // reset mid-scan aborts with no done
    @(negedge clk);
    start  = 1'b1;
    line_y = 8'd120;
    @(negedge clk);
    start = 1'b0;
    repeat (59) @(negedge clk);
    chk("abort_pre_count", 64'(list_count), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_count", 64'(list_count), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      bit saw_done = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      chk("abort_no_done", 64'(saw_done), 64'd0);
    end

    // full pass: every entry visible on row 0
    for (int i = 0; i < 128; i++)
      ram[i] = mk(8'(i), 16'h0100, 16'd10, 16'd0, 16'd10, 16'd0, 16'd10);
    do_scan(8'd0, -1, lat, seq_ok);
    chk("full_lat", 64'(lat), 64'd130);
    chk("full_seq", 64'(seq_ok), 64'd1);
    chk("full_count", 64'(list_count), 64'd16);
    chk("full_ovf", 64'(overflow), 64'd1);
    rd_list(15, v);
    chk("full_e15", 64'(v), 64'(ent(7'd15, 8'd15, 16'h0100, 9'd0, 9'd10)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_line_cull.md
Name: sprite_line_cull

Overview:
- Per-scanline culler that sits directly downstream of the sprite transform pre-pass.
- On each `start`, it reads every transformed sprite entry from the stmeta RAM read port, one sprite per cycle. It keeps the sprites that cover the requested screen row.
- Survivors are stored in a small list buffer, in ascending sprite index order, with X bounds clamped to the screen. The sprite scanline renderer reads this list.

Parameters:
- SPRITE_COUNT, 128, number of stmeta entries walked per scan. Power of two; address width is log2.
- MAX_PER_LINE, 16, list buffer depth. Power of two.
- WIDTH, 320, screen width in pixels; X clamp upper bound is WIDTH-1.
- HEIGHT, 240, screen height; line_y must be below this.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to cull row line_y. Ignored while busy=1.
- line_y  in  8  screen row (0..HEIGHT-1), sampled when start is accepted.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; list_count and list contents are final.
- stmeta_raddr  out  7  stmeta RAM read address. The RAM has synchronous read with 1-cycle latency.
- stmeta_read_data  in  120  stmeta entry. Fields, from MSB to LSB, all 16b fields signed:
  - [119:112] texture id
  - [111:96] transformY (Q8.8)
  - [95:80] screenX
  - [79:64] height
  - [63:48] drawStartY
  - [47:32] drawEndY
  - [31:16] drawStartX
  - [15:0] drawEndX
- list_count  out  5  number of valid list entries (0..MAX_PER_LINE).
- overflow  out  1  sticky; more than MAX_PER_LINE sprites were visible this scan.
- list_raddr  in  4  list read index.
- list_rdata  out  49  entry at list_raddr, combinational read, zero latency. Fields: {idx[6:0], tex[7:0], depth[15:0] = transformY, xstart[8:0], xend[8:0]}.

Behaviour:
- Reset (rst=0, async): state IDLE, stmeta_raddr=0, busy=0, done=0, list_count=0, overflow=0. List contents are don't-care.
- A reset during SCAN aborts the scan immediately; no done pulse is produced.
- States: IDLE, PRIME, SCAN, FINISH.
- IDLE: stmeta_raddr=0.
  - On start: latch line_y, clear list_count and overflow, go to PRIME.
- PRIME (cycle T1): issue address 1; the data for index 0 is valid next cycle. Go to SCAN.
- SCAN: at cycle T(k+2), evaluate entry k and issue address k+2 while k+2 < SPRITE_COUNT.
  - After evaluating k = SPRITE_COUNT-1 (T129), go to FINISH.
  - Address issue past the last index is don't-care.
- FINISH (T130): done=1 for one cycle, busy=0 in the same cycle, return to IDLE.
- Latency: start at T0 to done at T130 for SPRITE_COUNT=128, i.e. SPRITE_COUNT+2 cycles.
- Visibility test, all comparisons signed, line_y zero-extended to 16b. A sprite is visible when all of these hold:
  - transformY > 0 (strictly)
  - height != 0
  - drawStartY <= line_y <= drawEndY
  - drawEndX >= 0
  - drawStartX <= WIDTH-1
- Visible sprite with list_count < MAX_PER_LINE: write the entry at list_count, then increment list_count.
  - xstart = max(drawStartX, 0); xend = min(drawEndX, WIDTH-1), both 9b unsigned.
- Visible sprite with list_count == MAX_PER_LINE: the sprite is dropped, overflow is set, list_count stays at MAX_PER_LINE.
- Ordering: entries appear in ascending sprite index order. No depth sort is performed; the consumer sorts by depth.
- list_count and list_rdata may change during SCAN and are valid only from done until the next accepted start.
- list_rdata for list_raddr >= list_count is undefined.
- start while busy: ignored, with no effect on the scan in progress.
- start in the same cycle as done: ignored, because start is accepted only in IDLE. The consumer re-issues start afterwards.

Test Plan:
- Single sprite:
  - Stimulus: entry 5 = {tex 0x2A, tY 0x0200, sx 160, h 40, sy 100, ey 140, sx0 140, ex0 180}; all other entries have tY=0. start with line_y=120.
  - Required: done exactly 130 cycles after start; list_count=1; entry0 = {5, 0x2A, 0x0200, 140, 180}; overflow=0.
- Row boundaries: same sprite, line_y=100 gives count 1; line_y=140 gives count 1; line_y=99 and line_y=141 give count 0.
- Clamping and off-screen:
  - Entry with sx0=-30, ex0=350: accepted with xstart=0, xend=319.
  - Entry with ex0=-1: rejected. Entry with sx0=320: rejected. Entry with tY=0xFF00 (negative): rejected.
- Overflow: 20 visible sprites at indices 0..19. Required: list_count=16, overflow=1, last entry idx=15. A following scan with 3 visible sprites gives overflow=0 and count=3.
- Handshake: start pulsed again at T50. Required: ignored, and done still at T130 with unchanged results. rst pulled low at T60: busy=0, done never asserts, list_count=0.
- Full pass: all 128 entries visible on line_y=0. Required: count=16, overflow=1; stmeta_raddr sequence 0,1,2,...,127 with no skipped addresses.
